data_mem_ctrl: RTL and testbench

Parametrised, handshaked data memory for the pipelined CPU's MEM stage. It supersedes the single-cycle combinational-read data RAM.
- Accepts one load/store request at a time over valid/ready.
- Supports programmable wait states.
- Performs byte/half/word stores by lane.
- Sign/zero-extends loads and flags misaligned or out-of-range accesses instead of silently corrupting memory.

---
 rtl/data_mem_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Handshaked MEM-stage data memory: one request at a time, programmable wait states,
// lane-masked stores, sign/zero-extended loads and fault reporting for bad accesses.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned TRACE       = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               accept;
    logic               enter_resp;

    logic               we_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        pc_q;

    logic               acc_we;
    logic [1:0]         acc_size;
    logic               acc_uns;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic [31:0]        acc_pc;
    logic               acc_fault;
    logic [IDX_W-1:0]   acc_idx;
    logic [31:0]        old_word;
    logic [31:0]        lane_data;
    logic [3:0]         be;
    logic [31:0]        merged;
    logic [31:0]        ext_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    logic [31:0]        mem [DEPTH];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    // With no wait states the access happens on the accept edge, so use the live request
    always_comb begin
        acc_we    = we_q;
        acc_size  = size_q;
        acc_uns   = uns_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_pc    = pc_q;
        if (state_q == S_IDLE) begin
            acc_we    = req_we;
            acc_size  = req_size;
            acc_uns   = req_unsigned;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_pc    = req_pc;
        end
        acc_idx   = acc_addr[ADDR_W-1:2];
        acc_fault = (acc_size == 2'b11)
                  | ((acc_size == 2'b10) & acc_addr[0])
                  | ((acc_size == 2'b00) & (acc_addr[1:0] != 2'b00))
                  | (|acc_addr[31:ADDR_W]);
    end

    // Lane merge for stores and extension for loads
    always_comb begin
        old_word  = mem[acc_idx];
        lane_data = acc_wdata;
        be        = 4'b1111;
        ext_data  = old_word;
        ld_byte   = old_word[{acc_addr[1:0], 3'b000} +: 8];
        ld_half   = old_word[{acc_addr[1], 4'b0000} +: 16];
        case (acc_size)
            2'b01: begin
                lane_data = {4{acc_wdata[7:0]}};
                be        = 4'b0001 << acc_addr[1:0];
                ext_data  = acc_uns ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            2'b10: begin
                lane_data = {2{acc_wdata[15:0]}};
                be        = acc_addr[1] ? 4'b1100 : 4'b0011;
                ext_data  = acc_uns ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? lane_data[8*i +: 8] : old_word[8*i +: 8];
        end
    end

    // Request capture and registered response outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            pc_q      <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                pc_q    <= req_pc;
            end
            req_ready <= (state_d == S_IDLE);
            rsp_valid <= (state_d == S_RESP);
            busy      <= (state_d != S_IDLE);
            if (enter_resp) begin
                rsp_err   <= acc_fault;
                rsp_rdata <= (acc_fault || acc_we) ? 32'h0 : ext_data;
            end
        end
    end

    // Storage is deliberately not reset; a write retired before reset must survive it
    always_ff @(posedge clock) begin
        if (enter_resp && acc_we && !acc_fault) begin
            mem[acc_idx] <= merged;
        end
    end

    if (TRACE != 0) begin : g_trace
        always_ff @(posedge clock) begin
            if (enter_resp && acc_we && !acc_fault) begin
                $display("@%08h: *%08h <= %08h", acc_pc, acc_addr, merged);
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (0 and 3 wait states) driven through a shared,
// selectable port set and checked against a byte-lane arithmetic memory model.
module tb_data_mem_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_ready;

    logic        v0, v3, k0, k3;
    logic        rr0, rv0, re0, bz0;
    logic        rr3, rv3, re3, bz3;
    logic [31:0] rd0, rd3;
    logic        rr_m, rv_m, re_m, bz_m;
    logic [31:0] rd_m;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] model [int];

    always #5 clock = ~clock;

    assign v0   = req_valid & ~sel;
    assign v3   = req_valid & sel;
    assign k0   = rsp_ready & ~sel;
    assign k3   = rsp_ready & sel;
    assign rr_m = sel ? rr3 : rr0;
    assign rv_m = sel ? rv3 : rv0;
    assign re_m = sel ? re3 : re0;
    assign bz_m = sel ? bz3 : bz0;
    assign rd_m = sel ? rd3 : rd0;

    data_mem_ctrl #(.ADDR_W(13), .WAIT_CYCLES(0), .TRACE(1)) u_w0 (
        .clock(clock), .reset(reset),
        .req_valid(v0), .req_ready(rr0), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_pc(req_pc), .rsp_valid(rv0), .rsp_ready(k0), .rsp_rdata(rd0),
        .rsp_err(re0), .busy(bz0)
    );

    data_mem_ctrl #(.ADDR_W(13), .WAIT_CYCLES(3), .TRACE(1)) u_w3 (
        .clock(clock), .reset(reset),
        .req_valid(v3), .req_ready(rr3), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_pc(req_pc), .rsp_valid(rv3), .rsp_ready(k3), .rsp_rdata(rd3),
        .rsp_err(re3), .busy(bz3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    function automatic int wait_cycles();
        return sel ? 3 : 0;
    endfunction

    function automatic int mkey(input logic [31:0] addr);
        return (int'(sel) << 16) + int'(addr >> 2);
    endfunction

    // Reference: memory as words, lanes handled with shifts and masks
    task automatic model_exec(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] erd, output logic eerr);
        logic [31:0] w, v;
        int sh;
        bit fault;
        fault = (size == 2'd3) || (size == 2'd2 && (addr % 2) != 0) ||
                (size == 2'd0 && (addr % 4) != 0) || (addr >= 32'h2000);
        erd  = 32'h0;
        eerr = fault;
        if (fault) return;
        w  = model.exists(mkey(addr)) ? model[mkey(addr)] : 32'h0;
        sh = (size == 2'd2) ? 16 * int'((addr % 4) / 2) : 8 * int'(addr % 4);
        if (we) begin
            case (size)
                2'd0: w = wdata;
                2'd1: w = (w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
                default: w = (w & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
            endcase
            model[mkey(addr)] = w;
        end else begin
            case (size)
                2'd0: erd = w;
                2'd1: begin
                    v = (w >> sh) & 32'hFF;
                    if (!uns && v >= 32'd128) v = v - 32'd256;
                    erd = v;
                end
                default: begin
                    v = (w >> sh) & 32'hFFFF;
                    if (!uns && v >= 32'd32768) v = v - 32'd65536;
                    erd = v;
                end
            endcase
        end
    endtask

    task automatic wait_ready(input string tag, output bit ok);
        int n = 0;
        @(negedge clock);
        while (!rr_m && n < 100) begin
            @(negedge clock);
            n++;
        end
        ok = rr_m;
        if (!ok) check({tag, "_rdy_timeout"}, 32'(rr_m), 32'h1);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input string tag);
        logic [31:0] erd, first_rd;
        logic eerr, first_err;
        int lat;
        bit ok;
        model_exec(we, size, uns, addr, wdata, erd, eerr);
        wait_ready(tag, ok);
        if (!ok) return;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_pc       = $urandom & 32'hFFFF_FFFC;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!rv_m && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(wait_cycles() + 1));
        check({tag, "_rdata"}, rd_m, erd);
        check({tag, "_err"}, 32'(re_m), 32'(eerr));
        first_rd  = rd_m;
        first_err = re_m;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check({tag, "_hold_ctl"}, {28'h0, rv_m, rr_m, bz_m, re_m}, {28'h0, 3'b101, first_err});
            check({tag, "_hold_rdata"}, rd_m, first_rd);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        check({tag, "_release"}, {29'h0, rv_m, rr_m, bz_m}, 32'h2);
    endtask

    // req_valid held high; count how many requests the DUT takes in a fixed window
    task automatic back_to_back(input logic [31:0] base);
        logic [31:0] erd;
        logic eerr;
        int acc = 0;
        int n_cyc = 4 * (wait_cycles() + 2);
        bit ok;
        wait_ready("b2b", ok);
        rsp_ready    = 1'b1;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'd1;
        req_unsigned = 1'b0;
        for (int c = 0; c < n_cyc; c++) begin
            if (c > 0) @(negedge clock);
            req_addr  = base + 32'(acc % 4);
            req_wdata = $urandom;
            if (rr_m) begin
                model_exec(1'b1, 2'd1, 1'b0, req_addr, req_wdata, erd, eerr);
                acc++;
            end
        end
        req_valid = 1'b0;
        repeat (8) @(negedge clock);
        rsp_ready = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd4);
        do_req(1'b0, 2'd0, 1'b0, base, 32'h0, 0, "b2b_readback");
    endtask

    task automatic reset_mid_wait();
        bit ok;
        do_req(1'b1, 2'd0, 1'b0, 32'h40, 32'hCAFEF00D, 0, "rst_pre_sw40");
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0, "rst_pre_lw10");
        wait_ready("rst_sw", ok);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd0;
        req_addr  = 32'h40;
        req_wdata = 32'h12345678;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        check("rst_in_wait", {30'h0, rr_m, bz_m}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_async_ctl", {28'h0, rr_m, rv_m, bz_m, re_m}, 32'h8);
        check("rst_async_rdata", rd_m, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        do_req(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, 0, "rst_lw40");
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0, "rst_lw10");
    endtask

    task automatic directed();
        do_req(1'b1, 2'd0, 1'b0, 32'h10, 32'hDEADBEEF, 0, "sw10");
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 0, "lw10");
        do_req(1'b1, 2'd1, 1'b0, 32'h13, 32'h000000A5, 0, "sb13");
        do_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 0, "lb13");
        do_req(1'b0, 2'd1, 1'b1, 32'h13, 32'h0, 0, "lbu13");
        do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 0, "lh12");
        do_req(1'b0, 2'd2, 1'b1, 32'h12, 32'h0, 0, "lhu12");
        do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 0, "lw12_misaligned");
        do_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 0, "lh11_misaligned");
        do_req(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF, 0, "size3");
        do_req(1'b1, 2'd0, 1'b0, 32'h2000, 32'h55555555, 0, "sw_range");
        do_req(1'b1, 2'd2, 1'b0, 32'h12, 32'h1234FFFF, 0, "sh_bad_skip");
        do_req(1'b1, 2'd1, 1'b0, 32'h1F, 32'h00000077, 0, "sb_outside");
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 2, "lw10_hold");
    endtask

    task automatic random_phase();
        logic [31:0] addr;
        for (int w = 0; w < 16; w++)
            do_req(1'b1, 2'd0, 1'b0, 32'h100 + 32'(4 * w), $urandom, 0, "init");
        for (int i = 0; i < 60; i++) begin
            addr = 32'h100 + ($urandom % 64);
            if ($urandom % 8 == 0) addr = addr | (32'h1 << (13 + $urandom % 19));
            do_req(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), addr,
                   $urandom, int'($urandom % 3), "rnd");
        end
    endtask

    initial begin
        reset        = 1'b1;
        sel          = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_pc       = 32'h0;
        rsp_ready    = 1'b0;
        repeat (3) @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            check("reset_ctl", {28'h0, rr_m, rv_m, bz_m, re_m}, 32'h8);
            check("reset_rdata", rd_m, 32'h0);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            directed();
            back_to_back(32'h200);
            if (s == 1) reset_mid_wait();
            random_phase();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
